// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback scheduler.
package wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REGF_WIDTH = 32;
   localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

   // One writeback request: destination register plus result data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REGF_WIDTH-1:0] wdata;
   } wb_req_t;
endpackage

// File: rtl/wb_scheduler_if.sv
// Writeback requester bus: per-source valid/ready handshake with rd/wdata payload.
interface wb_scheduler_if #(parameter int NUM_SRC = 3);
   import wb_pkg::*;

   logic    [NUM_SRC-1:0] valid;
   logic    [NUM_SRC-1:0] ready;
   wb_req_t [NUM_SRC-1:0] req;

   modport master (output valid, output req, input ready);
   modport slave  (input valid, input req, output ready);
endinterface

// File: rtl/wb_prio_arb.sv
// Fixed-priority one-hot arbiter (index 0 highest). With WB_AGE_EN defined,
// requesters flagged as aged take precedence over all non-aged ones.
module wb_prio_arb #(
   parameter int NUM_SRC = 3
) (
   input  logic [NUM_SRC-1:0] valid_i,
`ifdef WB_AGE_EN
   input  logic [NUM_SRC-1:0] aged_i,
`endif
   output logic [NUM_SRC-1:0] grant_o
);
   logic [NUM_SRC-1:0] cand;
   logic               found;

   // Pick the lowest-index candidate; the aged set replaces the plain set when non-empty.
   always_comb begin
      cand    = valid_i;
`ifdef WB_AGE_EN
      if (|(aged_i & valid_i)) cand = aged_i & valid_i;
`endif
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cand[i] && !found) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-port scheduler with pending-write scoreboard.
// Optional build macro WB_AGE_EN: adds per-requester age counters so a starved
// requester is promoted after AGE_MAX denials (AGE_MAX exists only then).
// Data width is REGF_WIDTH from wb_pkg.
module wb_scheduler
   import wb_pkg::*;
#(
   parameter int NUM_SRC = 3
`ifdef WB_AGE_EN
   , parameter int AGE_MAX = 7
`endif
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   wb_scheduler_if.slave         src,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   input  logic [REG_ADDR_W-1:0] issue_rs1_i,
   input  logic [REG_ADDR_W-1:0] issue_rs2_i,
   output logic                  issue_hazard_o,
   output logic [31:0]           busy_vec_o,
   output logic                  rf_we_o,
   output logic [REG_ADDR_W-1:0] rf_waddr_o,
   output logic [REGF_WIDTH-1:0] rf_wdata_o
);
   logic [NUM_SRC-1:0]    grant;
   logic                  xfer;
   wb_req_t               sel;
   logic                  rf_we_d,    rf_we_q;
   logic [REG_ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
   logic [REGF_WIDTH-1:0] rf_wdata_d, rf_wdata_q;
   logic [31:0]           busy_d,     busy_q;

`ifdef WB_AGE_EN
   localparam int AGE_W = $clog2(AGE_MAX + 1);
   logic [NUM_SRC-1:0][AGE_W-1:0] age_d, age_q;
   logic [NUM_SRC-1:0]            aged;

   // A requester is promoted once its denial count saturates.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) aged[i] = (age_q[i] == AGE_W'(AGE_MAX));
   end
`endif

   wb_prio_arb #(.NUM_SRC(NUM_SRC)) u_arb (
      .valid_i (src.valid),
`ifdef WB_AGE_EN
      .aged_i  (aged),
`endif
      .grant_o (grant)
   );

   // No grants during reset or flush; the grant implies the requester is valid.
   assign src.ready = (reset_i || flush_i) ? '0 : grant;
   assign xfer      = |src.ready;

   // Mux out the granted request.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SRC; i++) if (src.ready[i]) sel = src.req[i];
   end

   // Output register: write only for non-x0 transfers, address/data hold otherwise.
   always_comb begin
      rf_we_d    = xfer && (sel.rd != X0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_we_d) begin
         rf_waddr_d = sel.rd;
         rf_wdata_d = sel.wdata;
      end
   end

   // Scoreboard: clear on writeback, then set on issue so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (xfer && sel.rd != X0) busy_d[sel.rd] = 1'b0;
      if (issue_valid_i && issue_rd_i != X0) busy_d[issue_rd_i] = 1'b1;
      if (flush_i) busy_d = '0;
      busy_d[0] = 1'b0;
   end

`ifdef WB_AGE_EN
   // Saturating denial counters, cleared on grant or flush.
   always_comb begin
      age_d = age_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (flush_i || src.ready[i]) age_d[i] = '0;
         else if (src.valid[i] && age_q[i] != AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
      end
   end

   // Age counter state.
   always_ff @(posedge clk_i) begin
      if (reset_i) age_q <= '0;
      else         age_q <= age_d;
   end
`endif

   // Output register and scoreboard state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_we_o        = rf_we_q;
   assign rf_waddr_o     = rf_waddr_q;
   assign rf_wdata_o     = rf_wdata_q;
   assign busy_vec_o     = busy_q;
   assign issue_hazard_o = issue_valid_i &&
                           (busy_q[issue_rs1_i] || busy_q[issue_rs2_i] || busy_q[issue_rd_i]);
endmodule

// File: tb/tb_wb_scheduler.sv
// Directed self-checking bench for wb_scheduler.
module tb_wb_scheduler;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_hazard;
   logic [31:0] busy_vec;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   int          checks = 0;
   int          errors = 0;

   wb_scheduler_if #(.NUM_SRC(3)) bus ();

   wb_scheduler #(.NUM_SRC(3)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .flush_i        (flush),
      .src            (bus),
      .issue_valid_i  (issue_valid),
      .issue_rd_i     (issue_rd),
      .issue_rs1_i    (issue_rs1),
      .issue_rs2_i    (issue_rs2),
      .issue_hazard_o (issue_hazard),
      .busy_vec_o     (busy_vec),
      .rf_we_o        (rf_we),
      .rf_waddr_o     (rf_waddr),
      .rf_wdata_o     (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
      bus.req[i].rd    = rd;
      bus.req[i].wdata = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.valid = 3'b001; set_req(0, 5'd4, 32'h1111);
      #1;
      checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", bus.ready); end
      tick(); tick();
      reset = 1'b0; bus.valid = 3'b000;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
      checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
   endtask

   task automatic test_priority();
      bus.valid = 3'b101; set_req(0, 5'd5, 32'hAAAA_0005); set_req(2, 5'd7, 32'hBBBB_0007);
      #1;
      checks++; if (bus.ready !== 3'b001) begin errors++; $display("FAIL prio_grant0 got=%b exp=001", bus.ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hAAAA_0005) begin errors++; $display("FAIL prio_write0 got=%b/%0d/%h exp=1/5/aaaa0005", rf_we, rf_waddr, rf_wdata); end
      bus.valid = 3'b100;
      #1;
      checks++; if (bus.ready !== 3'b100) begin errors++; $display("FAIL prio_grant2 got=%b exp=100", bus.ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB_0007) begin errors++; $display("FAIL prio_write2 got=%b/%0d/%h exp=1/7/bbbb0007", rf_we, rf_waddr, rf_wdata); end
      bus.valid = 3'b000;
      tick();
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB_0007) begin errors++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/7/bbbb0007", rf_we, rf_waddr, rf_wdata); end
   endtask

   task automatic test_hazard();
      issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      #1;
      checks++; if (issue_hazard !== 1'b0) begin errors++; $display("FAIL haz_first got=%b exp=0", issue_hazard); end
      tick();
      issue_rd = 5'd0; issue_rs1 = 5'd9;
      #1;
      checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL haz_busy_set got=%h exp=00000200", busy_vec); end
      checks++; if (issue_hazard !== 1'b1) begin errors++; $display("FAIL haz_rs1 got=%b exp=1", issue_hazard); end
      bus.valid = 3'b010; set_req(1, 5'd9, 32'h0000_0999);
      #1;
      checks++; if (bus.ready !== 3'b010 || issue_hazard !== 1'b1) begin errors++; $display("FAIL haz_no_bypass got=%b/%b exp=010/1", bus.ready, issue_hazard); end
      tick();
      bus.valid = 3'b000;
      #1;
      checks++; if (busy_vec !== 32'd0 || issue_hazard !== 1'b0) begin errors++; $display("FAIL haz_clear got=%h/%b exp=0/0", busy_vec, issue_hazard); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL haz_write got=%b/%0d exp=1/9", rf_we, rf_waddr); end
      issue_valid = 1'b0; issue_rs1 = 5'd0;
   endtask

   task automatic test_set_wins();
      issue_valid = 1'b1; issue_rd = 5'd3;
      bus.valid = 3'b001; set_req(0, 5'd3, 32'h0000_0333);
      tick();
      issue_valid = 1'b0; issue_rd = 5'd0;
      checks++; if (busy_vec !== 32'h0000_0008) begin errors++; $display("FAIL setwins_busy got=%h exp=00000008", busy_vec); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin errors++; $display("FAIL setwins_write got=%b/%0d exp=1/3", rf_we, rf_waddr); end
      tick();
      bus.valid = 3'b000;
      checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL setwins_clear got=%h exp=0", busy_vec); end
   endtask

   task automatic test_x0();
      bus.valid = 3'b100; set_req(2, 5'd0, 32'hDEAD);
      #1;
      checks++; if (bus.ready !== 3'b100) begin errors++; $display("FAIL x0_ready got=%b exp=100", bus.ready); end
      tick();
      bus.valid = 3'b000;
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || busy_vec !== 32'd0) begin errors++; $display("FAIL x0_nowrite got=%b/%0d/%h exp=0/3/0", rf_we, rf_waddr, busy_vec); end
   endtask

   task automatic test_flush();
      for (int r = 8; r < 12; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r);
         tick();
      end
      checks++; if (busy_vec !== 32'h0000_0F00) begin errors++; $display("FAIL flush_pre got=%h exp=00000f00", busy_vec); end
      flush = 1'b1; issue_rd = 5'd12; issue_rs1 = 5'd8;
      bus.valid = 3'b001; set_req(0, 5'd13, 32'h1313);
      #1;
      checks++; if (bus.ready !== 3'b000 || issue_hazard !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b/%b exp=000/1", bus.ready, issue_hazard); end
      tick();
      flush = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; bus.valid = 3'b000;
      checks++; if (busy_vec !== 32'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_after got=%h/%b exp=0/0", busy_vec, rf_we); end
   endtask

   task automatic test_reset_mid();
      tick();
      bus.valid = 3'b001; set_req(0, 5'd4, 32'h4444); reset = 1'b1;
      #1;
      checks++; if (bus.ready !== 3'b000) begin errors++; $display("FAIL rstmid_ready got=%b exp=000", bus.ready); end
      tick();
      reset = 1'b0; bus.valid = 3'b000;
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL rstmid_we got=%b/%0d exp=0/0", rf_we, rf_waddr); end
   endtask

   task automatic test_starve();
      logic [2:0] exp_rdy;
      logic       src2_pending;
      src2_pending = 1'b1;
      set_req(0, 5'd1, 32'h1); set_req(2, 5'd2, 32'h2);
      for (int c = 1; c <= 12; c++) begin
         bus.valid = {src2_pending, 2'b01};
`ifdef WB_AGE_EN
         exp_rdy = (c == 8) ? 3'b100 : 3'b001;
`else
         exp_rdy = 3'b001;
`endif
         #1;
         checks++; if (bus.ready !== exp_rdy) begin errors++; $display("FAIL starve_c%0d got=%b exp=%b", c, bus.ready, exp_rdy); end
         if (bus.ready[2]) src2_pending = 1'b0;
         tick();
      end
      bus.valid = 3'b000;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
      issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      bus.valid = 3'b000; bus.req = '0;
      tick();
      test_reset();
      test_priority();
      test_hazard();
      test_set_wins();
      test_x0();
      test_flush();
      test_reset_mid();
      test_starve();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
